priority_encoder_32to5: RTL
===========================

PRIORITY_ENCODER_32TO5 -- requirements
Module: priority_encoder_32to5

Interface
REQ-001 Parameter WIDTH, default 32: request vector width; fixed to 32 in this release.
REQ-002 Parameter IDX_W, default 5: encoded index width, equal to log2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  block enable; low freezes all state and masks out_valid.
REQ-006 req  input  32  request vector; bit i is source i (bit 0 pairs with decoder output O[0]).
REQ-007 load_valid  input  1  req is presented for capture.
REQ-008 load_ready  output  1  block can capture a new req vector.
REQ-009 out_valid  output  1  out_index holds a valid encoded request.
REQ-010 out_ready  input  1  consumer accepts out_index this cycle.
REQ-011 out_index  output  5  binary index of the current highest-priority pending bit.
REQ-012 out_last  output  1  current beat is the final pending bit of the captured vector.
REQ-013 empty_done  output  1  one-cycle pulse: a captured vector had no bits set.

Function
REQ-014 Two states, IDLE and BUSY; the reset state is IDLE.
REQ-015 load_ready SHALL be 1 only when the state is IDLE and enable = 1.
REQ-016 A load occurs when load_valid and load_ready are both 1; req is then copied into a 32-bit pending register.
REQ-017 A load of a nonzero vector in cycle N SHALL move the state to BUSY, with out_valid = 1 from cycle N+1 (one-cycle latency).
REQ-018 A load of an all-zero vector SHALL keep the state at IDLE and pulse empty_done for exactly cycle N+1; out_valid stays 0.
REQ-019 In BUSY, out_index SHALL equal the lowest set bit index of the pending register (LSB has the highest priority).
REQ-020 out_last SHALL be 1 in BUSY exactly when the pending register has a single bit set.
REQ-021 A transfer occurs when out_valid and out_ready are both 1; the served bit is cleared at that edge.
REQ-022 A transfer with out_last = 1 SHALL return the state to IDLE, so load_ready = 1 in the next cycle (back-to-back vectors allowed).
REQ-023 While out_valid = 1 and out_ready = 0, out_index and out_last SHALL hold stable.
REQ-024 req and load_valid are ignored in BUSY; in-flight vectors are never merged.
REQ-025 With enable = 0: out_valid = 0, load_ready = 0, empty_done = 0, and the pending register and state hold; operation resumes unchanged when enable returns to 1.
REQ-026 out_index and out_last SHALL read 0 whenever out_valid = 0.

Reset
REQ-027 Reset asserted at any time, including mid-vector, SHALL immediately force state = IDLE, pending = 0, out_valid = 0, out_index = 0, out_last = 0, empty_done = 0, and load_ready = 0.
REQ-028 After reset release, load_ready follows REQ-015 from the first clock edge.

Configuration
REQ-029 Macro PENDING_COUNT_EN defined: add output pending_count (6 bits), the registered popcount of the pending register (0..32); it is 0 on reset, is loaded with popcount(req) on a load, and decrements by 1 on each transfer.
REQ-030 Macro PENDING_COUNT_EN undefined: the pending_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 Shared package enc_pkg SHALL hold WIDTH, IDX_W, and the IDLE/BUSY state encoding.
REQ-032 Sub-module pri_enc32 (combinational 32-to-5 lowest-set-bit finder with a "none" flag) SHALL produce out_index and be instantiated once.

Verification
REQ-033 Load req = 0x8000_0011 with out_ready = 1 -> out_index sequence 0, 4, 31 on consecutive cycles, with out_last only on 31, then load_ready = 1.
REQ-034 Load req = 0x0000_0000 -> empty_done = 1 for exactly one cycle, out_valid never 1, and the state stays IDLE.
REQ-035 Load 0x0000_0006 and hold out_ready = 0 for 3 cycles -> out_index = 1 stable for 3 cycles; then release -> 1, then 2 with out_last.
REQ-036 Load 0xFFFF_FFFF and assert reset after 10 transfers -> all outputs 0 and IDLE immediately; a new load of 0x0000_0001 then yields index 0 with out_last.
REQ-037 Drop enable for 2 cycles mid-vector 0x0000_0300 -> out_valid = 0 during the gap, then indices 8 and 9 are still delivered, with no loss or duplicate.
REQ-038 With PENDING_COUNT_EN defined: load 0x0000_00F0 -> pending_count 4, 3, 2, 1, 0 across the transfers.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants, FSM encoding and encoder result type for the
// 32-to-5 priority encoder block.
package enc_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Lowest-set-bit search result; none=1 means the vector was all zero.
  typedef struct packed {
    logic             none;
    logic [IDX_W-1:0] idx;
  } enc_res_t;

  // Number of set bits in a request vector (0..WIDTH).
  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/pri_enc32.sv
// Combinational 32-to-5 lowest-set-bit finder with a "none" flag.
// The vector is split into NUM_LANES slices; each lane resolves its own
// lowest bit and the lowest non-empty lane wins.

// Per-lane lowest-set-bit finder.
module pri_lane #(
  parameter int LANE_W = 8,
  parameter int LIDX_W = 3
) (
  input  logic [LANE_W-1:0] vec,
  output logic              any,
  output logic [LIDX_W-1:0] idx
);

  // Scan from MSB down so the lowest set bit is the last to write idx.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = LANE_W - 1; i >= 0; i--)
      if (vec[i]) idx = LIDX_W'(i);
  end

endmodule

module pri_enc32 import enc_pkg::*; #(
  parameter int NUM_LANES = 4
) (
  input  logic [WIDTH-1:0] vec,
  output enc_res_t         res
);

  localparam int LANE_W = WIDTH / NUM_LANES;
  localparam int LIDX_W = $clog2(LANE_W);
  localparam int LSEL_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_vec;
  logic [NUM_LANES-1:0]             lane_any;
  logic [NUM_LANES-1:0][LIDX_W-1:0] lane_idx;

  assign lane_vec = vec;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      pri_lane #(
        .LANE_W (LANE_W),
        .LIDX_W (LIDX_W)
      ) u_lane (
        .vec (lane_vec[g]),
        .any (lane_any[g]),
        .idx (lane_idx[g])
      );
    end
  endgenerate

  // Lowest non-empty lane supplies the upper index bits.
  always_comb begin
    res.none = 1'b1;
    res.idx  = '0;
    for (int g = NUM_LANES - 1; g >= 0; g--)
      if (lane_any[g]) begin
        res.none = 1'b0;
        res.idx  = {LSEL_W'(g), lane_idx[g]};
      end
  end

endmodule

// File: rtl/priority_encoder_32to5.sv
// Priority encoder: captures a 32-bit request vector and serves its set
// bits one per transfer, lowest index first, over a valid/ready port.
// Optional feature macro: PENDING_COUNT_EN adds the pending_count output
// (registered popcount of the pending bits).
module priority_encoder_32to5 import enc_pkg::*; #(
  parameter int WIDTH = enc_pkg::WIDTH,
  parameter int IDX_W = enc_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] req,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             empty_done
`ifdef PENDING_COUNT_EN
  , output logic [IDX_W:0] pending_count
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             empty_q, empty_d;
  logic             load_fire, xfer;
  logic             live, busy_v, single;
  enc_res_t         enc;

  pri_enc32 u_enc (
    .vec (pend_q),
    .res (enc)
  );

  // Outputs are masked while reset is held so they read 0 immediately.
  assign live   = enable & ~reset;
  assign busy_v = (state_q == BUSY) & ~enc.none;
  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign single = ~|(pend_q & (pend_q - WIDTH'(1)));

  // State, pending vector and empty pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      empty_q <= empty_d;
    end
  end

  // Next-state, handshake and output decode; enable low holds everything.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    empty_d    = 1'b0;
    load_ready = 1'b0;
    load_fire  = 1'b0;
    out_valid  = 1'b0;
    out_index  = '0;
    out_last   = 1'b0;
    xfer       = 1'b0;
    empty_done = empty_q & live;
    if (live) begin
      case (state_q)
        IDLE: begin
          load_ready = 1'b1;
          if (load_valid) begin
            load_fire = 1'b1;
            if (req == '0) begin
              empty_d = 1'b1;
            end else begin
              pend_d  = req;
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          out_valid = busy_v;
          out_index = busy_v ? enc.idx : '0;
          out_last  = busy_v & single;
          if (enc.none) begin
            state_d = IDLE;
          end else if (out_ready) begin
            xfer   = 1'b1;
            pend_d = pend_q & (pend_q - WIDTH'(1));
            if (single) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PENDING_COUNT_EN
  logic [IDX_W:0] cnt_q;

  // Running count of bits still to be served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt_q <= '0;
    else if (load_fire) cnt_q <= popcnt(req);
    else if (xfer)      cnt_q <= cnt_q - 1'b1;
  end

  assign pending_count = cnt_q;
`else
  logic unused_fire;
  assign unused_fire = load_fire ^ xfer;
`endif

endmodule
